// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: two write ports,
// NUM_RD read ports with busy bits, and scoreboard set/flush controls.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     we0;
  logic [ADDR_W-1:0]        wa0;
  logic [DATA_W-1:0]        wd0;
  logic                     we1;
  logic [ADDR_W-1:0]        wa1;
  logic [DATA_W-1:0]        wd1;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic                     sb_flush;

  modport master (
    output we0, wa0, wd0,
    output we1, wa1, wd1,
    output ra, sb_set, sb_addr, sb_flush,
    input  rd, rd_busy
  );

  modport slave (
    input  we0, wa0, wd0,
    input  we1, wa1, wd1,
    input  ra, sb_set, sb_addr, sb_flush,
    output rd, rd_busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with busy scoreboard; reg 0 reads as zero.
// Ports: clk, rst (sync, active-high), bus (reg_file_mp_if.slave):
//   we0/wa0/wd0, we1/wa1/wd1 (port 1 wins), ra->rd/rd_busy,
//   sb_set/sb_addr marks busy, sb_flush clears all busy bits.
// Optional macro RF_BYPASS_EN: write-through reads of same-cycle writes.
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input logic           clk,
  input logic           rst,
  reg_file_mp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wv0;
  logic              wv1;
  logic              sv;

  assign wv0 = bus.we0 && (bus.wa0 != '0);
  assign wv1 = bus.we1 && (bus.wa1 != '0);
  assign sv  = bus.sb_set && (bus.sb_addr != '0);

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      if (wv0) regs[bus.wa0] <= bus.wd0;
      if (wv1) regs[bus.wa1] <= bus.wd1;
    end
  end

  // Set is applied after the write clears: a new producer
  // issued alongside the old one's writeback stays in flight.
  always_comb begin
    busy_nxt = busy;
    if (bus.sb_flush) begin
      busy_nxt = '0;
    end else begin
      if (wv0) busy_nxt[bus.wa0] = 1'b0;
      if (wv1) busy_nxt[bus.wa1] = 1'b0;
      if (sv)  busy_nxt[bus.sb_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = bus.ra[g*ADDR_W +: ADDR_W];

    always_comb begin
      d = (a == '0) ? '0 : regs[a];
      b = busy[a];
`ifdef RF_BYPASS_EN
      if (!rst && (a != '0)) begin
        if (wv1 && (bus.wa1 == a)) begin
          d = bus.wd1;
          b = bus.sb_set && (bus.sb_addr == a);
        end else if (wv0 && (bus.wa0 == a)) begin
          d = bus.wd0;
          b = bus.sb_set && (bus.sb_addr == a);
        end
      end
`endif
    end

    assign bus.rd[g*DATA_W +: DATA_W] = d;
    assign bus.rd_busy[g] = b;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed vector table,
// hand sequences for write-through/reset, and a randomized model run.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        chk;
    bit        rs;
    bit        we0;
    bit [4:0]  wa0;
    bit [31:0] wd0;
    bit        we1;
    bit [4:0]  wa1;
    bit [31:0] wd1;
    bit        sbs;
    bit [4:0]  sba;
    bit        fl;
    bit [4:0]  r0;
    bit [4:0]  r1;
    bit [31:0] e0;
    bit [31:0] e1;
    bit [1:0]  eb;
  } vec_t;

  vec_t tv[22];

  // Reference state: plain arrays updated by the stated rules.
  bit [31:0] mregs [32];
  bit        mbusy [32];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(bit rs, bit we0, bit [4:0] wa0, bit [31:0] wd0,
                       bit we1, bit [4:0] wa1, bit [31:0] wd1,
                       bit sbs, bit [4:0] sba, bit fl,
                       bit [4:0] r0, bit [4:0] r1);
    rst          = rs;
    bus.we0      = we0;
    bus.wa0      = wa0;
    bus.wd0      = wd0;
    bus.we1      = we1;
    bus.wa1      = wa1;
    bus.wd1      = wd1;
    bus.sb_set   = sbs;
    bus.sb_addr  = sba;
    bus.sb_flush = fl;
    bus.ra       = {r1, r0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(bit c, bit rs,
    bit we0, bit [4:0] wa0, bit [31:0] wd0,
    bit we1, bit [4:0] wa1, bit [31:0] wd1,
    bit sbs, bit [4:0] sba, bit fl,
    bit [4:0] r0, bit [4:0] r1,
    bit [31:0] e0, bit [31:0] e1, bit [1:0] eb);
    vec_t t;
    t.chk = c;   t.rs = rs;
    t.we0 = we0; t.wa0 = wa0; t.wd0 = wd0;
    t.we1 = we1; t.wa1 = wa1; t.wd1 = wd1;
    t.sbs = sbs; t.sba = sba; t.fl = fl;
    t.r0 = r0;   t.r1 = r1;
    t.e0 = e0;   t.e1 = e1;   t.eb = eb;
    return t;
  endfunction

  function automatic bit [31:0] exp_rd(bit [4:0] a);
    if (a == 0) return 0;
`ifdef RF_BYPASS_EN
    if (!rst) begin
      if (bus.we1 && bus.wa1 == a) return bus.wd1;
      if (bus.we0 && bus.wa0 == a) return bus.wd0;
    end
`endif
    return mregs[a];
  endfunction

  function automatic bit exp_busy(bit [4:0] a);
    if (a == 0) return 0;
`ifdef RF_BYPASS_EN
    if (!rst && ((bus.we1 && bus.wa1 == a) ||
                 (bus.we0 && bus.wa0 == a)))
      return bus.sb_set && bus.sb_addr == a;
`endif
    return mbusy[a];
  endfunction

  task automatic model_step();
    if (rst) begin
      foreach (mregs[i]) begin
        mregs[i] = 0;
        mbusy[i] = 0;
      end
      return;
    end
    if (bus.we0 && bus.wa0 != 0) mregs[bus.wa0] = bus.wd0;
    if (bus.we1 && bus.wa1 != 0) mregs[bus.wa1] = bus.wd1;
    if (bus.sb_flush) begin
      foreach (mbusy[i]) mbusy[i] = 0;
    end else begin
      if (bus.we0 && bus.wa0 != 0) mbusy[bus.wa0] = 0;
      if (bus.we1 && bus.wa1 != 0) mbusy[bus.wa1] = 0;
      if (bus.sb_set && bus.sb_addr != 0) mbusy[bus.sb_addr] = 1;
    end
  endtask

  initial begin
    bit [4:0] a0;
    bit [4:0] a1;

    //        c rs we0 wa0 wd0  we1 wa1 wd1  sbs sba fl r0 r1  e0 e1 eb
    tv[0]  = v(0,1, 0,0,0,       0,0,0,       0,0,0,  1,31, 0,0,2'b00);
    tv[1]  = v(1,0, 0,0,0,       0,0,0,       0,0,0,  1,31, 0,0,2'b00);
    tv[2]  = v(1,0, 1,1,10,      0,0,0,       0,0,0,  3,31, 0,0,2'b00);
    tv[3]  = v(1,0, 1,2,9,       0,0,0,       0,0,0,  1,0,  10,0,2'b00);
    tv[4]  = v(1,0, 0,0,0,       0,0,0,       0,0,0,  1,2,  10,9,2'b00);
    tv[5]  = v(1,0, 1,0,11,      0,0,0,       1,0,0,  0,1,  0,10,2'b00);
    tv[6]  = v(1,0, 0,0,0,       0,0,0,       0,0,0,  0,0,  0,0,2'b00);
    tv[7]  = v(1,0, 1,5,7,       1,5,8,       0,0,0,  1,2,  10,9,2'b00);
    tv[8]  = v(1,0, 0,0,0,       0,0,0,       0,0,0,  5,1,  8,10,2'b00);
    tv[9]  = v(1,0, 0,0,0,       0,0,0,       1,3,0,  3,5,  0,8,2'b00);
    tv[10] = v(1,0, 0,0,0,       0,0,0,       0,0,0,  3,1,  0,10,2'b01);
    tv[11] = v(1,0, 0,0,0,       1,3,32'hAB,  0,0,0,  1,2,  10,9,2'b00);
    tv[12] = v(1,0, 0,0,0,       0,0,0,       0,0,0,  3,3,  32'hAB,32'hAB,2'b00);
    tv[13] = v(1,0, 1,3,32'hCD,  0,0,0,       1,3,0,  5,1,  8,10,2'b00);
    tv[14] = v(1,0, 0,0,0,       0,0,0,       1,7,0,  3,7,  32'hCD,0,2'b01);
    tv[15] = v(1,0, 0,0,0,       0,0,0,       1,9,1,  3,7,  32'hCD,0,2'b11);
    tv[16] = v(1,0, 0,0,0,       0,0,0,       0,0,0,  3,9,  32'hCD,0,2'b00);
    tv[17] = v(1,1, 1,4,32'h55,  0,0,0,       1,4,0,  5,3,  8,32'hCD,2'b00);
    tv[18] = v(1,0, 0,0,0,       0,0,0,       0,0,0,  4,5,  0,0,2'b00);
    tv[19] = v(1,0, 0,0,0,       0,0,0,       1,6,0,  6,1,  0,0,2'b00);
    tv[20] = v(1,1, 0,0,0,       0,0,0,       0,0,0,  6,1,  0,0,2'b01);
    tv[21] = v(1,0, 0,0,0,       0,0,0,       0,0,0,  6,1,  0,0,2'b00);

    drive(1, 0,0,0, 0,0,0, 0,0,0, 0,0);
    tick();

    for (int i = 0; i < 22; i++) begin
      drive(tv[i].rs, tv[i].we0, tv[i].wa0, tv[i].wd0,
            tv[i].we1, tv[i].wa1, tv[i].wd1,
            tv[i].sbs, tv[i].sba, tv[i].fl,
            tv[i].r0, tv[i].r1);
      @(negedge clk);
      if (tv[i].chk) begin
        chk($sformatf("vec%0d rd0", i), bus.rd[31:0], tv[i].e0);
        chk($sformatf("vec%0d rd1", i), bus.rd[63:32], tv[i].e1);
        chk($sformatf("vec%0d busy", i),
            {30'd0, bus.rd_busy}, {30'd0, tv[i].eb});
      end
      tick();
    end

    // Same-cycle write/read of reg 4, then reset during a write.
    drive(0, 1,4,32'h11, 0,0,0, 0,0,0, 1,2);
    tick();
    drive(0, 1,4,32'h55, 0,0,0, 0,0,0, 4,0);
    @(negedge clk);
`ifdef RF_BYPASS_EN
    chk("wt same cycle", bus.rd[31:0], 32'h55);
`else
    chk("wt same cycle", bus.rd[31:0], 32'h11);
`endif
    chk("wt same busy", {31'd0, bus.rd_busy[0]}, 32'd0);
    tick();
    drive(0, 0,0,0, 0,0,0, 0,0,0, 4,0);
    @(negedge clk);
    chk("wt next cycle", bus.rd[31:0], 32'h55);
    tick();
    drive(1, 1,4,32'h77, 0,0,0, 1,4,0, 4,0);
    @(negedge clk);
    chk("rst write rd", bus.rd[31:0], 32'h55);
    chk("rst write busy", {31'd0, bus.rd_busy[0]}, 32'd0);
    tick();
    drive(0, 0,0,0, 0,0,0, 0,0,0, 4,0);
    @(negedge clk);
    chk("after rst rd", bus.rd[31:0], 32'd0);
    chk("after rst busy", {31'd0, bus.rd_busy[0]}, 32'd0);
    tick();

    // Randomized run against the array model; small address
    // range so collisions between ports are frequent.
    drive(1, 0,0,0, 0,0,0, 0,0,0, 0,0);
    model_step();
    tick();
    for (int n = 0; n < 400; n++) begin
      a0 = 5'($urandom_range(0, 7));
      a1 = 5'($urandom_range(0, 7));
      drive(($urandom_range(0, 49) == 0),
            1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 19) == 0),
            a0, a1);
      @(negedge clk);
      chk("rand rd0", bus.rd[31:0], exp_rd(a0));
      chk("rand rd1", bus.rd[63:32], exp_rd(a1));
      chk("rand busy", {30'd0, bus.rd_busy},
          {30'd0, exp_busy(a1), exp_busy(a0)});
      model_step();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
